// File: rtl/label_stats_if.sv
// Record stream carrying one per-label statistics record from label_stats
// to its consumer.
//   stat_valid  record present (master -> slave)
//   stat_ready  consumer accepts on stat_valid & stat_ready at clk edge
//   stat_label  label id
//   stat_area   pixel count, 1..2**(2*IMG_W_LOG2)
//   stat_xmin/stat_xmax/stat_ymin/stat_ymax  inclusive bounding box
interface label_stats_if #(
  parameter int unsigned IMG_W_LOG2 = 5
);
  logic                    stat_valid;
  logic                    stat_ready;
  logic [7:0]              stat_label;
  logic [2*IMG_W_LOG2:0]   stat_area;
  logic [IMG_W_LOG2-1:0]   stat_xmin;
  logic [IMG_W_LOG2-1:0]   stat_xmax;
  logic [IMG_W_LOG2-1:0]   stat_ymin;
  logic [IMG_W_LOG2-1:0]   stat_ymax;

  modport master (
    output stat_valid, stat_label, stat_area,
           stat_xmin, stat_xmax, stat_ymin, stat_ymax,
    input  stat_ready
  );

  modport slave (
    input  stat_valid, stat_label, stat_area,
           stat_xmin, stat_xmax, stat_ymin, stat_ymax,
    output stat_ready
  );
endinterface

// File: rtl/label_stats.sv
// Per-label area / bounding-box statistics over a finished label map.
// On start, reads every word of the square label SRAM (address = {y,x}),
// accumulates area and bbox for labels 1..MAX_LABELS, then streams one
// record per present label in ascending order and raises done.
//   clk, reset  rising-edge clock, synchronous active-low reset
//   start       one-cycle pulse, honoured in IDLE/DONE only
//   sram_a      read address (holds last value outside SCAN)
//   sram_q      read data, valid the cycle after sram_a
//   stat        record stream (master side)
//   overflow    sticky per run: a label above MAX_LABELS was read
//   busy        high in SCAN/DRAIN/EMIT
//   done        level, high in DONE until the next start
module label_stats #(
  parameter int unsigned MAX_LABELS = 16,
  parameter int unsigned IMG_W_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [2*IMG_W_LOG2-1:0] sram_a,
  input  logic [7:0]              sram_q,
  label_stats_if.master           stat,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
);
  localparam int unsigned CW = IMG_W_LOG2;
  localparam int unsigned AW = 2 * IMG_W_LOG2;
  localparam int unsigned NW = AW + 1;
  localparam int unsigned IW = $clog2(MAX_LABELS + 2);
  localparam logic [NW-1:0] AREA_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EMIT, DONE} state_t;
  state_t state;

  // Entry i holds label i+1.
  logic [NW-1:0] t_area [MAX_LABELS];
  logic [CW-1:0] t_xmin [MAX_LABELS];
  logic [CW-1:0] t_xmax [MAX_LABELS];
  logic [CW-1:0] t_ymin [MAX_LABELS];
  logic [CW-1:0] t_ymax [MAX_LABELS];

  // Address of the word currently on sram_q.
  logic          rd_v;
  logic [AW-1:0] rd_a;
  logic [CW-1:0] rd_x;
  logic [CW-1:0] rd_y;

  // Next label id to consider in EMIT.
  logic [IW-1:0] idx;
  logic          any_left;
  logic [NW-1:0] cur_area;
  logic [CW-1:0] cur_xmin, cur_xmax, cur_ymin, cur_ymax;

  assign rd_x = rd_a[CW-1:0];
  assign rd_y = rd_a[AW-1:CW];
  assign busy = (state == SCAN) || (state == DRAIN) || (state == EMIT);

  // any_left lets EMIT finish as soon as no present label remains at or
  // above idx, so an empty table leaves EMIT after a single cycle.
  always_comb begin
    any_left = 1'b0;
    cur_area = '0;
    cur_xmin = '0;
    cur_xmax = '0;
    cur_ymin = '0;
    cur_ymax = '0;
    for (int unsigned i = 0; i < MAX_LABELS; i++) begin
      if (t_area[i] != '0 && IW'(i + 1) >= idx) any_left = 1'b1;
      if (IW'(i + 1) == idx) begin
        cur_area = t_area[i];
        cur_xmin = t_xmin[i];
        cur_xmax = t_xmax[i];
        cur_ymin = t_ymin[i];
        cur_ymax = t_ymax[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      sram_a          <= '0;
      rd_v            <= 1'b0;
      rd_a            <= '0;
      idx             <= '0;
      overflow        <= 1'b0;
      done            <= 1'b0;
      stat.stat_valid <= 1'b0;
      stat.stat_label <= '0;
      stat.stat_area  <= '0;
      stat.stat_xmin  <= '0;
      stat.stat_xmax  <= '0;
      stat.stat_ymin  <= '0;
      stat.stat_ymax  <= '0;
      for (int unsigned i = 0; i < MAX_LABELS; i++) begin
        t_area[i] <= '0;
        t_xmin[i] <= '1;
        t_xmax[i] <= '0;
        t_ymin[i] <= '1;
        t_ymax[i] <= '0;
      end
    end else begin
      rd_v <= (state == SCAN);
      rd_a <= sram_a;

      if (rd_v) begin
        if (sram_q > 8'(MAX_LABELS)) begin
          overflow <= 1'b1;
        end else begin
          for (int unsigned i = 0; i < MAX_LABELS; i++) begin
            if (sram_q == 8'(i + 1)) begin
              if (t_area[i] != AREA_MAX) t_area[i] <= t_area[i] + 1'b1;
              if (rd_x < t_xmin[i]) t_xmin[i] <= rd_x;
              if (rd_x > t_xmax[i]) t_xmax[i] <= rd_x;
              if (rd_y < t_ymin[i]) t_ymin[i] <= rd_y;
              if (rd_y > t_ymax[i]) t_ymax[i] <= rd_y;
            end
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SCAN;
            sram_a   <= '0;
            idx      <= IW'(1);
            overflow <= 1'b0;
            done     <= 1'b0;
            for (int unsigned i = 0; i < MAX_LABELS; i++) begin
              t_area[i] <= '0;
              t_xmin[i] <= '1;
              t_xmax[i] <= '0;
              t_ymin[i] <= '1;
              t_ymax[i] <= '0;
            end
          end
        end
        SCAN: begin
          if (sram_a == '1) state <= DRAIN;
          else              sram_a <= sram_a + 1'b1;
        end
        // The final word is accumulated on the DRAIN->EMIT edge.
        DRAIN: state <= EMIT;
        EMIT: begin
          if (!stat.stat_valid || stat.stat_ready) begin
            if (!any_left) begin
              stat.stat_valid <= 1'b0;
              state           <= DONE;
              done            <= 1'b1;
            end else begin
              idx             <= idx + 1'b1;
              stat.stat_valid <= (cur_area != '0);
              if (cur_area != '0) begin
                stat.stat_label <= 8'(idx);
                stat.stat_area  <= cur_area;
                stat.stat_xmin  <= cur_xmin;
                stat.stat_xmax  <= cur_xmax;
                stat.stat_ymin  <= cur_ymin;
                stat.stat_ymax  <= cur_ymax;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_label_stats.sv
module tb_label_stats;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] sram_a;
  logic [7:0] sram_q;
  logic       overflow, busy, done;
  logic [7:0] mem [1024];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct packed {
    logic [7:0]  label;
    logic [10:0] area;
    logic [4:0]  xmin;
    logic [4:0]  xmax;
    logic [4:0]  ymin;
    logic [4:0]  ymax;
  } rec_t;

  rec_t exp_q[$];

  label_stats_if #(.IMG_W_LOG2(5)) stat();

  label_stats #(.MAX_LABELS(16), .IMG_W_LOG2(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sram_a(sram_a), .sram_q(sram_q), .stat(stat),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sram_q <= mem[sram_a];

  task automatic clear_mem();
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
  endtask

  task automatic put(input int x, input int y, input logic [7:0] l);
    mem[y * 32 + x] = l;
  endtask

  // Reference model: histogram + bbox per label, records pushed in label order.
  task automatic build_expected(output logic ovf, output int unsigned last, output int unsigned n);
    int unsigned cnt[16];
    int unsigned xmn[16], xmx[16], ymn[16], ymx[16];
    rec_t r;
    ovf = 1'b0; last = 0; n = 0;
    exp_q.delete();
    for (int l = 0; l < 16; l++) begin
      cnt[l] = 0; xmn[l] = 99; xmx[l] = 0; ymn[l] = 99; ymx[l] = 0;
    end
    for (int a = 0; a < 1024; a++) begin
      int unsigned l, x, y;
      l = mem[a]; x = a % 32; y = a / 32;
      if (l > 16) ovf = 1'b1;
      else if (l != 0) begin
        cnt[l-1]++;
        if (x < xmn[l-1]) xmn[l-1] = x;
        if (x > xmx[l-1]) xmx[l-1] = x;
        if (y < ymn[l-1]) ymn[l-1] = y;
        if (y > ymx[l-1]) ymx[l-1] = y;
      end
    end
    for (int unsigned l = 0; l < 16; l++) begin
      if (cnt[l] != 0) begin
        r = {8'(l + 1), 11'(cnt[l]), 5'(xmn[l]), 5'(xmx[l]), 5'(ymn[l]), 5'(ymx[l])};
        exp_q.push_back(r);
        last = l + 1;
        n++;
      end
    end
  endtask

  // Pulses start, then consumes records (stall cycles before each accept),
  // popping the scoreboard on every accepted record. done_cyc counts edges
  // after the edge that sampled start.
  task automatic run_scan(input int unsigned stall, output int unsigned done_cyc);
    rec_t got, held, e;
    int unsigned scnt;
    bit holding;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    done_cyc = 0; holding = 0; scnt = 0;
    for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        stat.stat_ready = 1'b0;
        return;
      end
      got = {stat.stat_label, stat.stat_area, stat.stat_xmin, stat.stat_xmax,
             stat.stat_ymin, stat.stat_ymax};
      if (stat.stat_valid) begin
        if (holding) begin
          vectors++;
          if (got !== held) begin
            miscompares++;
            $display("FAIL stall_stable: got %h expected %h", got, held);
          end
        end
        stat.stat_ready = (scnt >= stall);
        if (stat.stat_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_record: got %h expected none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              miscompares++;
              $display("FAIL record: got %h expected %h", got, e);
            end
          end
          holding = 0; scnt = 0;
        end else begin
          holding = 1; held = got; scnt++;
        end
      end else begin
        stat.stat_ready = 1'b0;
        if (holding) begin
          vectors++; miscompares++;
          $display("FAIL valid_dropped: got valid 0 expected 1 while stalled");
          holding = 0;
        end
      end
      @(negedge clk);
    end
    stat.stat_ready = 1'b0;
    vectors++; miscompares++;
    $display("FAIL done_timeout: got no done expected done within 4000 cycles");
  endtask

  task automatic test_reset();
    logic [52:0] all;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    all = {sram_a, stat.stat_valid, stat.stat_label, stat.stat_area, stat.stat_xmin,
           stat.stat_xmax, stat.stat_ymin, stat.stat_ymax, overflow, busy, done};
    vectors++;
    if (all !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", all);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Generic scenario: run the current map and check records, done timing,
  // overflow and final output levels.
  task automatic test_map(input string name, input int unsigned stall);
    logic ovf; int unsigned last, n, dc, exp_dc;
    build_expected(ovf, last, n);
    run_scan(stall, dc);
    exp_dc = 1026 + last + stall * n;
    vectors++;
    if (dc !== exp_dc) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, dc, exp_dc);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_records: got %0d left expected 0", name, exp_q.size());
    end
    vectors++;
    if (overflow !== ovf) begin
      miscompares++;
      $display("FAIL %s overflow: got %b expected %b", name, overflow, ovf);
    end
    vectors++;
    if ({busy, stat.stat_valid, sram_a} !== {1'b0, 1'b0, 10'h3FF}) begin
      miscompares++;
      $display("FAIL %s final_levels: got busy=%b valid=%b a=%h expected 0 0 3ff",
               name, busy, stat.stat_valid, sram_a);
    end
  endtask

  task automatic test_empty();
    clear_mem();
    test_map("empty", 0);
  endtask

  task automatic test_single();
    clear_mem();
    mem[1023] = 8'd1;
    test_map("single", 0);
  endtask

  task automatic test_full();
    for (int a = 0; a < 1024; a++) mem[a] = 8'd1;
    test_map("full", 0);
  endtask

  task automatic load_two_labels();
    clear_mem();
    put(3, 4, 8'd2); put(5, 9, 8'd2); put(0, 0, 8'd5);
  endtask

  task automatic test_two_labels();
    load_two_labels();
    test_map("two_labels", 0);
  endtask

  task automatic test_stall();
    load_two_labels();
    test_map("stall", 10);
  endtask

  task automatic test_back_to_back();
    clear_mem();
    put(31, 0, 8'd1); put(0, 31, 8'd2); put(17, 12, 8'd3); put(18, 13, 8'd3);
    put(30, 31, 8'd16);
    put(1, 0, 8'd16);
    test_map("back_to_back", 0);
  endtask

  task automatic test_overflow();
    clear_mem();
    put(7, 2, 8'd20); put(7, 3, 8'd3); put(10, 20, 8'd3); put(31, 31, 8'd17);
    test_map("overflow", 0);
  endtask

  task automatic test_reset_mid_scan();
    logic [52:0] all;
    load_two_labels();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    vectors++;
    if ({busy, sram_a} !== {1'b1, 10'd100}) begin
      miscompares++;
      $display("FAIL mid_scan: got busy=%b a=%0d expected 1 100", busy, sram_a);
    end
    reset = 1'b0;
    @(negedge clk);
    all = {sram_a, stat.stat_valid, stat.stat_label, stat.stat_area, stat.stat_xmin,
           stat.stat_xmax, stat.stat_ymin, stat.stat_ymax, overflow, busy, done};
    vectors++;
    if (all !== '0) begin
      miscompares++;
      $display("FAIL mid_scan_reset: got %h expected 0", all);
    end
    reset = 1'b1;
    @(negedge clk);
    test_map("after_reset", 0);
  endtask

  initial begin
    stat.stat_ready = 1'b0;
    clear_mem();
    test_reset();
    test_empty();
    test_single();
    test_full();
    test_two_labels();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
